// File: rtl/mem_indirect_ctrl.sv
// MEM-stage sequencer for LC-3b LDI/STI: pointer read followed by a data read or write.
// Optional performance counters are enabled with the MEM_IND_PERF_EN macro.
module mem_indirect_ctrl #(
    parameter int WIDTH  = 16,
    parameter int PERF_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             is_ldi,
    input  logic             is_sti,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] st_data,
    input  logic             dmem_resp,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [WIDTH-1:0] dmem_address,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    output logic             ind_owns_port,
    output logic [WIDTH-1:0] ind_rdata,
    output logic             ind_done,
    output logic             mem_indirect_stall
`ifdef MEM_IND_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_ind_ops,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    // Memory handshake: dmem_read/dmem_write stay high with a stable address and
    // wdata until the cycle dmem_resp is seen; at most one of them is ever high.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PTR_RD  = 3'd1,
        DATA_RD = 3'd2,
        DATA_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    logic             req;
    logic             op_ldi;
    logic [WIDTH-1:0] ea_q;
    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] wdata_q;

    assign req = mem_valid & (is_ldi | is_sti);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_ldi    <= 1'b0;
            ea_q      <= '0;
            ptr       <= '0;
            wdata_q   <= '0;
            ind_rdata <= '0;
            ind_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ind_done <= 1'b0;
                    if (req) begin
                        state   <= PTR_RD;
                        op_ldi  <= is_ldi;
                        ea_q    <= ea;
                        wdata_q <= st_data;
                    end
                end
                PTR_RD: begin
                    if (dmem_resp) begin
                        ptr <= {dmem_rdata[WIDTH-1:1], 1'b0};
                        // A flushed op finishes the pointer read but skips the data access.
                        if (!req)        state <= IDLE;
                        else if (op_ldi) state <= DATA_RD;
                        else             state <= DATA_WR;
                    end
                end
                DATA_RD: begin
                    if (dmem_resp) begin
                        ind_rdata <= dmem_rdata;
                        if (req) begin
                            state    <= DONE;
                            ind_done <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA_WR: begin
                    if (dmem_resp) begin
                        if (req) begin
                            state    <= DONE;
                            ind_done <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    ind_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    ind_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Port outputs decode straight from the state register, so they drop with async reset.
    always_comb begin
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = '0;
        case (state)
            PTR_RD: begin
                dmem_read    = 1'b1;
                dmem_address = ea_q;
            end
            DATA_RD: begin
                dmem_read    = 1'b1;
                dmem_address = ptr;
            end
            DATA_WR: begin
                dmem_write   = 1'b1;
                dmem_address = ptr;
                dmem_wdata   = wdata_q;
            end
            default: ;
        endcase
    end

    assign dmem_byte_enable   = 2'b11;
    assign ind_owns_port      = (state != IDLE) | req;
    assign mem_indirect_stall = req & (state != DONE) & ~rst;

`ifdef MEM_IND_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ind_ops      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state == DONE && perf_ind_ops != {PERF_W{1'b1}})
                perf_ind_ops <= perf_ind_ops + 1'b1;
            if (mem_indirect_stall && perf_stall_cycles != {PERF_W{1'b1}})
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_indirect_ctrl.sv
// Bench for mem_indirect_ctrl: directed LDI/STI sequences against a latency-programmable
// memory model, with an expected-transaction queue checked by an independent monitor.
module tb_mem_indirect_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_valid = 1'b0;
    logic         is_ldi = 1'b0;
    logic         is_sti = 1'b0;
    logic [W-1:0] ea = '0;
    logic [W-1:0] st_data = '0;
    logic         mem_resp = 1'b0;
    logic         extra_resp = 1'b0;
    logic         dmem_resp;
    logic [W-1:0] dmem_rdata = '0;
    logic         dmem_read;
    logic         dmem_write;
    logic [W-1:0] dmem_address;
    logic [W-1:0] dmem_wdata;
    logic [1:0]   dmem_byte_enable;
    logic         ind_owns_port;
    logic [W-1:0] ind_rdata;
    logic         ind_done;
    logic         mem_indirect_stall;
`ifdef MEM_IND_PERF_EN
    logic [15:0]  perf_ind_ops;
    logic [15:0]  perf_stall_cycles;
`endif

    assign dmem_resp = mem_resp | extra_resp;

    always #5 clk = ~clk;

    mem_indirect_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .mem_valid          (mem_valid),
        .is_ldi             (is_ldi),
        .is_sti             (is_sti),
        .ea                 (ea),
        .st_data            (st_data),
        .dmem_resp          (dmem_resp),
        .dmem_rdata         (dmem_rdata),
        .dmem_read          (dmem_read),
        .dmem_write         (dmem_write),
        .dmem_address       (dmem_address),
        .dmem_wdata         (dmem_wdata),
        .dmem_byte_enable   (dmem_byte_enable),
        .ind_owns_port      (ind_owns_port),
        .ind_rdata          (ind_rdata),
        .ind_done           (ind_done),
        .mem_indirect_stall (mem_indirect_stall)
`ifdef MEM_IND_PERF_EN
        ,
        .perf_ind_ops       (perf_ind_ops),
        .perf_stall_cycles  (perf_stall_cycles)
`endif
    );

    // Entry layout: {kind[1:0], address[15:0], data[15:0]}
    // kind 0 = read, 1 = write, 2 = LDI done with rdata, 3 = STI done (data unchecked)
    logic [33:0]  exp_q[$];
    logic [W-1:0] mem [0:65535];
    int           n_lat = 1;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_pop(input string name, input logic [33:0] act);
        logic [33:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected actual=%h expected=none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e[33:32] == 2'd3) begin
                e[33:32] = 2'd2;
                e[15:0]  = act[15:0];
            end
            if (act !== e) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h", name, act, e);
            end
        end
    endtask

    // Memory model: responds in the n_lat-th cycle of each request.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !(dmem_read || dmem_write)) begin
                cnt = 0;
                mem_resp = 1'b0;
            end else begin
                cnt++;
                if (cnt >= n_lat) begin
                    cnt = 0;
                    mem_resp = 1'b1;
                    if (dmem_write) begin
                        mem[dmem_address] = dmem_wdata;
                        dmem_rdata = '0;
                    end else begin
                        dmem_rdata = mem[dmem_address];
                    end
                end else begin
                    mem_resp = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every completed access and every done cycle against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dmem_read || dmem_write)
                    check("rw_exclusive", {31'd0, dmem_read & dmem_write}, 32'd0);
                if (dmem_resp && (dmem_read || dmem_write))
                    compare_pop("access", {dmem_write ? 2'd1 : 2'd0, dmem_address,
                                           dmem_write ? dmem_wdata : dmem_rdata});
                if (ind_done)
                    compare_pop("done", {2'd2, 16'h0000, ind_rdata});
            end
        end
    end

    task automatic run_op(input bit ldi, input logic [W-1:0] a, input logic [W-1:0] sd,
                          input int n, input logic [W-1:0] ptr_word, input logic [W-1:0] ptr,
                          input logic [W-1:0] data, input int exp_stall);
        int stalls;
        stalls = 0;
        exp_q.push_back({2'd0, a, ptr_word});
        if (ldi) begin
            exp_q.push_back({2'd0, ptr, data});
            exp_q.push_back({2'd2, 16'h0000, data});
        end else begin
            exp_q.push_back({2'd1, ptr, sd});
            exp_q.push_back({2'd3, 16'h0000, 16'h0000});
        end
        n_lat = n;
        mem_valid = 1'b1;
        is_ldi = ldi;
        is_sti = !ldi;
        ea = a;
        st_data = sd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_indirect_stall) stalls++;
            else break;
        end
        check(ldi ? "ldi_stall_cycles" : "sti_stall_cycles", stalls, exp_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        mem_valid = 1'b0;
        is_ldi = 1'b0;
        is_sti = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h1000] = 16'h2001;
        mem[16'h2000] = 16'hBEEF;
        mem[16'h0040] = 16'h3000;
        mem[16'h0100] = 16'h0501;
        mem[16'h0500] = 16'hCAFE;
        mem[16'h0102] = 16'h0601;

        // Reset state, with a request already presented
        mem_valid = 1'b1;
        is_ldi = 1'b1;
        ea = 16'h1000;
        @(negedge clk);
        check("rst_stall", {31'd0, mem_indirect_stall}, 32'd0);
        check("rst_read_write", {30'd0, dmem_read, dmem_write}, 32'd0);
        check("rst_address", {16'd0, dmem_address}, 32'd0);
        check("rst_wdata", {16'd0, dmem_wdata}, 32'd0);
        check("rst_done", {31'd0, ind_done}, 32'd0);
        check("rst_rdata", {16'd0, ind_rdata}, 32'd0);
        check("byte_enable", {30'd0, dmem_byte_enable}, 32'd3);
        mem_valid = 1'b0;
        is_ldi = 1'b0;
        @(negedge clk);
        check("rst_owns_port", {31'd0, ind_owns_port}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LDI with single-cycle memory, twice back to back
        run_op(1'b1, 16'h1000, 16'h0000, 1, 16'h2001, 16'h2000, 16'hBEEF, 3);
        run_op(1'b1, 16'h1000, 16'h0000, 1, 16'h2001, 16'h2000, 16'hBEEF, 3);
        go_idle();
`ifdef MEM_IND_PERF_EN
        check("perf_ind_ops", {16'd0, perf_ind_ops}, 32'd2);
        check("perf_stall_cycles", {16'd0, perf_stall_cycles}, 32'd6);
`endif

        // STI with three-cycle memory
        run_op(1'b0, 16'h0040, 16'h1234, 3, 16'h3000, 16'h3000, 16'h1234, 7);
        go_idle();
        check("sti_mem_3000", {16'd0, mem[16'h3000]}, 32'h1234);

        // Back-to-back LDI then STI, odd pointer word forced to word alignment
        run_op(1'b1, 16'h0100, 16'h0000, 2, 16'h0501, 16'h0500, 16'hCAFE, 5);
        run_op(1'b0, 16'h0102, 16'h5A5A, 2, 16'h0601, 16'h0600, 16'h5A5A, 5);
        go_idle();
        check("sti_mem_0600", {16'd0, mem[16'h0600]}, 32'h5A5A);

        // Plain LDR in MEM: no stall, no ownership, no requests
        mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ldr_stall", {31'd0, mem_indirect_stall}, 32'd0);
            check("ldr_owns_port", {31'd0, ind_owns_port}, 32'd0);
            check("ldr_requests", {30'd0, dmem_read, dmem_write}, 32'd0);
        end
        go_idle();

        // Reset during DATA_RD, then a stray response
        n_lat = 3;
        exp_q.push_back({2'd0, 16'h1000, 16'h2001});
        mem_valid = 1'b1;
        is_ldi = 1'b1;
        ea = 16'h1000;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_read && dmem_address == 16'h2000) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_data_rd", {31'd0, found}, 32'd1);
        rst = 1'b1;
        mem_valid = 1'b0;
        is_ldi = 1'b0;
        #1;
        check("midrst_requests", {30'd0, dmem_read, dmem_write}, 32'd0);
        check("midrst_address", {16'd0, dmem_address}, 32'd0);
        check("midrst_stall", {31'd0, mem_indirect_stall}, 32'd0);
        check("midrst_rdata", {16'd0, ind_rdata}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #3;
        extra_resp = 1'b1;
        @(posedge clk);
        #3;
        extra_resp = 1'b0;
        @(negedge clk);
        check("postrst_requests", {30'd0, dmem_read, dmem_write}, 32'd0);
        check("postrst_owns_port", {31'd0, ind_owns_port}, 32'd0);
        check("postrst_done", {31'd0, ind_done}, 32'd0);
        @(posedge clk);
        #1;
        run_op(1'b1, 16'h1000, 16'h0000, 1, 16'h2001, 16'h2000, 16'hBEEF, 3);
        go_idle();
`ifdef MEM_IND_PERF_EN
        check("perf_ind_ops_after_rst", {16'd0, perf_ind_ops}, 32'd1);
        check("perf_stall_after_rst", {16'd0, perf_stall_cycles}, 32'd3);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
